// File: rtl/rv32i_clint_bridge.sv
// rv32i_clint_bridge
//   Machine-timer / software-interrupt controller placed in front of rv32i_soc.
//   Keeps shadow copies of mtime and mtimecmp, advances mtime once per
//   microsecond (CLK_FREQ_MHZ core cycles), and forwards timer values and
//   interrupt levels to the core. Host access is a single-beat stb/we/ack bus.
//
// Parameters
//   CLK_FREQ_MHZ   core clock in MHz; mtime advances every CLK_FREQ_MHZ cycles
//   MTIME_SYNC_US  mtime shadow is re-pushed to the core every MTIME_SYNC_US ticks
//
// Configuration macro
//   CLINT_EXT_IRQ_SYNC_EN  defined: i_ext_irq goes through a 2-flop synchronizer
//                          undefined: i_ext_irq is passed straight through
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_stb/i_we/i_addr      bus request, direction, byte offset
//   i_wdata/i_wsel         write data and byte enables
//   o_ack/o_rdata          one-cycle acknowledge, read data valid with ack
//   i_ext_irq              external interrupt request (level)
//   o_software_interrupt   msip[0]
//   o_external_interrupt   external interrupt to core
//   o_mtime_wr/_din        one-cycle load pulse and value for core mtime
//   o_mtimecmp_wr/_din     one-cycle load pulse and value for core mtimecmp
//   o_timer_pending        registered unsigned (mtime >= mtimecmp)

module rv32i_clint_bridge #(
  parameter int unsigned CLK_FREQ_MHZ  = 100,
  parameter int unsigned MTIME_SYNC_US = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  input  logic        i_ext_irq,
  output logic        o_software_interrupt,
  output logic        o_external_interrupt,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_timer_pending
);

  localparam int unsigned PRE_W  = (CLK_FREQ_MHZ  > 1) ? $clog2(CLK_FREQ_MHZ)  : 1;
  localparam int unsigned SYNC_W = (MTIME_SYNC_US > 1) ? $clog2(MTIME_SYNC_US) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_FREQ_MHZ - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(MTIME_SYNC_US - 1);

  typedef enum logic [4:0] {
    REG_MSIP        = 5'h00,
    REG_MTIMECMP_LO = 5'h08,
    REG_MTIMECMP_HI = 5'h0C,
    REG_MTIME_LO    = 5'h10,
    REG_MTIME_HI    = 5'h14
  } reg_addr_e;

  logic [63:0]       mtime_shadow;
  logic [63:0]       mtimecmp_shadow;
  logic [63:0]       mtime_next;
  logic [63:0]       mtimecmp_next;
  logic [PRE_W-1:0]  prescaler;
  logic [SYNC_W-1:0] sync_cnt;
  logic              mtime_push;
  logic              mtimecmp_push;
  logic [31:0]       rd_val;

  logic accept;
  logic wr_en;
  logic tick;
  logic sync_hit;
  logic wr_msip;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_mtime;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // A request held across the ack cycle is not a new request.
  assign accept      = i_stb & ~o_ack;
  assign wr_en       = accept & i_we;
  assign wr_msip     = wr_en & (i_addr == REG_MSIP);
  assign wr_cmp_lo   = wr_en & (i_addr == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en & (i_addr == REG_MTIMECMP_HI);
  assign wr_mtime_lo = wr_en & (i_addr == REG_MTIME_LO);
  assign wr_mtime_hi = wr_en & (i_addr == REG_MTIME_HI);
  assign wr_mtime    = wr_mtime_lo | wr_mtime_hi;

  assign tick     = (prescaler == PRE_LAST);
  assign sync_hit = tick & (sync_cnt == SYNC_LAST);

  always_comb begin
    rd_val = '0;
    case (i_addr)
      REG_MSIP:        rd_val = {31'b0, o_software_interrupt};
      REG_MTIMECMP_LO: rd_val = mtimecmp_shadow[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp_shadow[63:32];
      REG_MTIME_LO:    rd_val = mtime_shadow[31:0];
      REG_MTIME_HI:    rd_val = mtime_shadow[63:32];
      default:         rd_val = '0;
    endcase
  end

  // A bus write to mtime overrides a coincident tick: the merge uses the
  // pre-tick value and the increment is dropped.
  always_comb begin
    mtime_next = tick ? (mtime_shadow + 64'd1) : mtime_shadow;
    if (wr_mtime_lo) mtime_next = {mtime_shadow[63:32], merge_bytes(mtime_shadow[31:0], i_wdata, i_wsel)};
    if (wr_mtime_hi) mtime_next = {merge_bytes(mtime_shadow[63:32], i_wdata, i_wsel), mtime_shadow[31:0]};
  end

  always_comb begin
    mtimecmp_next = mtimecmp_shadow;
    if (wr_cmp_lo) mtimecmp_next = {mtimecmp_shadow[63:32], merge_bytes(mtimecmp_shadow[31:0], i_wdata, i_wsel)};
    if (wr_cmp_hi) mtimecmp_next = {merge_bytes(mtimecmp_shadow[63:32], i_wdata, i_wsel), mtimecmp_shadow[31:0]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack                <= 1'b0;
      o_rdata              <= '0;
      o_software_interrupt <= 1'b0;
      mtime_shadow         <= '0;
      mtimecmp_shadow      <= '1;
      prescaler            <= '0;
      sync_cnt             <= '0;
      mtime_push           <= 1'b0;
      mtimecmp_push        <= 1'b0;
      o_mtime_wr           <= 1'b0;
      o_mtime_din          <= '0;
      o_mtimecmp_wr        <= 1'b0;
      o_mtimecmp_din       <= '1;
      o_timer_pending      <= 1'b0;
    end else begin
      o_ack   <= accept;
      o_rdata <= (accept & ~i_we) ? rd_val : '0;

      if (wr_msip && i_wsel[0]) o_software_interrupt <= i_wdata[0];

      mtime_shadow    <= mtime_next;
      mtimecmp_shadow <= mtimecmp_next;

      if (wr_mtime || tick) prescaler <= '0;
      else                  prescaler <= prescaler + 1'b1;

      if (wr_mtime || sync_hit) sync_cnt <= '0;
      else if (tick)            sync_cnt <= sync_cnt + 1'b1;

      // Both push sources land in one flag, so a periodic sync coinciding
      // with a bus write yields a single pulse carrying the written value.
      mtime_push    <= wr_mtime | sync_hit;
      mtimecmp_push <= wr_cmp_lo | wr_cmp_hi;

      o_mtime_wr <= mtime_push;
      if (mtime_push) o_mtime_din <= mtime_shadow;

      o_mtimecmp_wr <= mtimecmp_push;
      if (mtimecmp_push) o_mtimecmp_din <= mtimecmp_shadow;

      o_timer_pending <= (mtime_shadow >= mtimecmp_shadow);
    end
  end

`ifdef CLINT_EXT_IRQ_SYNC_EN
  logic ext_meta;
  logic ext_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ext_meta <= 1'b0;
      ext_sync <= 1'b0;
    end else begin
      ext_meta <= i_ext_irq;
      ext_sync <= ext_meta;
    end
  end

  assign o_external_interrupt = ext_sync;
`else
  assign o_external_interrupt = i_ext_irq;
`endif

endmodule

// File: tb/tb_rv32i_clint_bridge.sv
module tb_rv32i_clint_bridge;

  localparam longint unsigned CLK  = 100;
  localparam longint unsigned SYNC = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_stb;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wsel;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        i_ext_irq;
  logic        o_software_interrupt;
  logic        o_external_interrupt;
  logic        o_mtime_wr;
  logic [63:0] o_mtime_din;
  logic        o_mtimecmp_wr;
  logic [63:0] o_mtimecmp_din;
  logic        o_timer_pending;

  rv32i_clint_bridge #(
    .CLK_FREQ_MHZ (100),
    .MTIME_SYNC_US(4)
  ) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_stb               (i_stb),
    .i_we                (i_we),
    .i_addr              (i_addr),
    .i_wdata             (i_wdata),
    .i_wsel              (i_wsel),
    .o_ack               (o_ack),
    .o_rdata             (o_rdata),
    .i_ext_irq           (i_ext_irq),
    .o_software_interrupt(o_software_interrupt),
    .o_external_interrupt(o_external_interrupt),
    .o_mtime_wr          (o_mtime_wr),
    .o_mtime_din         (o_mtime_din),
    .o_mtimecmp_wr       (o_mtimecmp_wr),
    .o_mtimecmp_din      (o_mtimecmp_din),
    .o_timer_pending     (o_timer_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mtime is described as: value written at edge base_w, plus whole
  // microseconds elapsed since then.
  longint unsigned m_e;
  longint unsigned m_base_w;
  logic [63:0]     m_base_val;
  logic [63:0]     m_cmp;
  logic            m_msip;
  logic            m_ack;
  logic [31:0]     m_rdata;
  logic            m_mpush, m_cpush;
  logic            m_mtime_wr, m_cmp_wr;
  logic [63:0]     m_mtime_din, m_cmp_din;
  logic            m_pending;
  logic            m_s1, m_s2;

  function automatic logic [63:0] mtime_at(input longint unsigned e, input longint unsigned bw,
                                           input logic [63:0] bv);
    return bv + 64'((e - bw) / CLK);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    logic [63:0]     mt_pre;
    logic            acc;
    logic            mwrite;
    longint unsigned e_new, k_old, k_new;
    if (i_rst) begin
      m_e = 0; m_base_w = 0; m_base_val = '0; m_cmp = '1; m_msip = 0;
      m_ack = 0; m_rdata = '0; m_mpush = 0; m_cpush = 0;
      m_mtime_wr = 0; m_cmp_wr = 0; m_mtime_din = '0; m_cmp_din = '1;
      m_pending = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      mt_pre = mtime_at(m_e, m_base_w, m_base_val);
      acc    = i_stb && !m_ack;
      e_new  = m_e + 1;
      m_pending  = (mt_pre >= m_cmp);
      m_mtime_wr = m_mpush;
      if (m_mpush) m_mtime_din = mt_pre;
      m_cmp_wr = m_cpush;
      if (m_cpush) m_cmp_din = m_cmp;
      m_mpush = 0; m_cpush = 0; mwrite = 0;
      m_rdata = '0;
      if (acc && !i_we) begin
        case (i_addr)
          5'h00: m_rdata = {31'b0, m_msip};
          5'h08: m_rdata = m_cmp[31:0];
          5'h0C: m_rdata = m_cmp[63:32];
          5'h10: m_rdata = mt_pre[31:0];
          5'h14: m_rdata = mt_pre[63:32];
          default: m_rdata = '0;
        endcase
      end
      if (acc && i_we) begin
        case (i_addr)
          5'h00: if (i_wsel[0]) m_msip = i_wdata[0];
          5'h08: begin m_cmp[31:0]  = lane_merge(m_cmp[31:0],  i_wdata, i_wsel); m_cpush = 1; end
          5'h0C: begin m_cmp[63:32] = lane_merge(m_cmp[63:32], i_wdata, i_wsel); m_cpush = 1; end
          5'h10: begin
            m_base_val = {mt_pre[63:32], lane_merge(mt_pre[31:0], i_wdata, i_wsel)};
            m_base_w = e_new; mwrite = 1; m_mpush = 1;
          end
          5'h14: begin
            m_base_val = {lane_merge(mt_pre[63:32], i_wdata, i_wsel), mt_pre[31:0]};
            m_base_w = e_new; mwrite = 1; m_mpush = 1;
          end
          default: ;
        endcase
      end
      m_ack = acc;
      if (!mwrite) begin
        k_old = (m_e - m_base_w) / CLK;
        k_new = (e_new - m_base_w) / CLK;
        if (k_new != k_old && (k_new % SYNC) == 0) m_mpush = 1;
      end
      m_s2 = m_s1;
      m_s1 = i_ext_irq;
      m_e  = e_new;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("ack", o_ack, m_ack);
      if (m_ack) check("rdata", o_rdata, m_rdata);
      check("software_interrupt", o_software_interrupt, m_msip);
`ifdef CLINT_EXT_IRQ_SYNC_EN
      check("external_interrupt", o_external_interrupt, m_s2);
`else
      check("external_interrupt", o_external_interrupt, i_ext_irq);
`endif
      check("mtime_wr", o_mtime_wr, m_mtime_wr);
      check("mtime_din", o_mtime_din, m_mtime_din);
      check("mtimecmp_wr", o_mtimecmp_wr, m_cmp_wr);
      check("mtimecmp_din", o_mtimecmp_din, m_cmp_din);
      check("timer_pending", o_timer_pending, m_pending);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic [4:0] a, input logic we, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd);
    i_stb = 1; i_we = we; i_addr = a; i_wdata = wd; i_wsel = ws;
    @(posedge i_clk); #2;
    i_stb = 0; i_we = 0;
    check("bus_ack", o_ack, 64'd1);
    rd = o_rdata;
    @(posedge i_clk); #2;
    check("bus_ack_drop", o_ack, 64'd0);
  endtask

  task automatic do_reset();
    i_rst = 1; i_stb = 0; i_we = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
  endtask

  task automatic wait_edge(input longint unsigned n);
    while (m_e < n) @(negedge i_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0] addr_tab [9] = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h04, 5'h18, 5'h1C, 5'h01};

  initial begin
    logic [31:0] rd;
    logic [4:0]  a;
    i_rst = 1; i_stb = 0; i_we = 0; i_addr = '0; i_wdata = '0; i_wsel = '0; i_ext_irq = 0;
    do_reset();

    // 1: reset arriving just after a write is accepted cancels it
    i_stb = 1; i_we = 1; i_addr = 5'h08; i_wdata = 32'h5; i_wsel = 4'hF;
    @(posedge i_clk); #1;
    i_rst = 1; i_stb = 0; i_we = 0;
    #1;
    check("rst_ack", o_ack, 64'd0);
    check("rst_cmp_din", o_mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_mtime_din", o_mtime_din, 64'd0);
    check("rst_pending", o_timer_pending, 64'd0);
    check("rst_msip", o_software_interrupt, 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    repeat (3) begin
      @(negedge i_clk);
      check("post_rst_ack", o_ack, 64'd0);
      check("post_rst_mtime_wr", o_mtime_wr, 64'd0);
      check("post_rst_cmp_wr", o_mtimecmp_wr, 64'd0);
    end

    // 2: mtimecmp low write, pulse one cycle after ack
    bus(5'h08, 1, 32'h0000_000F, 4'hF, rd);
    check("cmp_wr_pulse", o_mtimecmp_wr, 64'd1);
    check("cmp_din_lo", o_mtimecmp_din, 64'hFFFF_FFFF_0000_000F);
    bus(5'h0C, 1, 32'h0, 4'hF, rd);
    check("cmp_din_full", o_mtimecmp_din, 64'h0000_0000_0000_000F);

    // 3: mtime reaches 15 after 1500 edges, pending one cycle later
    wait_edge(1500);
    check("pending_at_1500", o_timer_pending, 64'd0);
    @(negedge i_clk);
    check("pending_at_1501", o_timer_pending, 64'd1);
    @(posedge i_clk); #2;

    // 4: msip write/read
    bus(5'h00, 1, 32'h1, 4'h1, rd);
    check("msip_set", o_software_interrupt, 64'd1);
    bus(5'h00, 0, 32'h0, 4'h0, rd);
    check("msip_read1", rd, 64'd1);
    bus(5'h00, 1, 32'h0, 4'h1, rd);
    check("msip_clr", o_software_interrupt, 64'd0);
    bus(5'h00, 0, 32'h0, 4'h0, rd);
    check("msip_read0", rd, 64'd0);

    // 6: unmapped read and external interrupt latency
    bus(5'h1C, 0, 32'h0, 4'h0, rd);
    check("unmapped_read", rd, 64'd0);
    i_ext_irq = 1;
    #1;
`ifdef CLINT_EXT_IRQ_SYNC_EN
    check("ext_lat0", o_external_interrupt, 64'd0);
    @(posedge i_clk); #1;
    check("ext_lat1", o_external_interrupt, 64'd0);
    @(posedge i_clk); #1;
    check("ext_lat2", o_external_interrupt, 64'd1);
`else
    check("ext_comb", o_external_interrupt, 64'd1);
`endif
    @(posedge i_clk); #2;
    i_ext_irq = 0;

    // 5: mtime_hi write on the same edge as the first tick
    @(posedge i_clk); #2;
    do_reset();
    wait_edge(99);
    bus(5'h14, 1, 32'h0000_DEAD, 4'b0011, rd);
    check("mtime_wr_pulse", o_mtime_wr, 64'd1);
    check("mtime_din_hi", o_mtime_din, 64'h0000_DEAD_0000_0000);
    bus(5'h10, 0, 32'h0, 4'h0, rd);
    check("mtime_lo_no_inc", rd, 64'd0);
    bus(5'h14, 0, 32'h0, 4'h0, rd);
    check("mtime_hi_read", rd, 64'h0000_DEAD);

    // randomized traffic checked by the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(posedge i_clk); #2;
      a = addr_tab[$urandom_range(0, 8)];
      i_stb   = ($urandom_range(0, 2) == 0);
      i_we    = $urandom_range(0, 1);
      i_addr  = a;
      i_wsel  = 4'($urandom);
      if ((a == 5'h10 || a == 5'h14) && $urandom_range(0, 39) != 0) i_we = 0;
      if ($urandom_range(0, 3) != 0)
        i_wdata = (a == 5'h0C || a == 5'h14) ? 32'h0 : $urandom_range(0, 60);
      else
        i_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) i_ext_irq = ~i_ext_irq;
    end
    @(posedge i_clk); #2;
    i_stb = 0; i_we = 0;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
